seg7_scan_decoder: RTL
======================

// Module: seg7_scan_decoder
// PURPOSE
//  - Receive end of the 4-digit multiplexed 7-segment scan bus (active-low anodes, active-low dot+g..a cathodes).
//  - Samples anode_n/cathode_n each scan tick and decodes each segment pattern back to BCD.
//  - Assembles complete 4-digit frames and publishes the 16-bit BCD value with valid/error status.
//  - Used for display readback, self-check and board-level loopback of the display driver.
// PARAMETERS
//  - STALE_CYCLES  16  clk_1khz cycles without a committed frame before bcd_data_valid drops (>=5)
// PORTS
//  - clk_1khz       in   1   scan clock; same clock and edge as the driving display scanner
//  - reset          in   1   synchronous, active-high
//  - anode_n        in   4   digit select, active-low one-hot-zero: 1110=d0, 1101=d1, 1011=d2, 0111=d3
//  - cathode_n      in   8   segments, active-low: [7]=dot, [6:0]=g..a
//  - bcd_data_op    out  16  last committed frame; [3:0]=d0 ... [15:12]=d3; blank digit = 4'hF
//  - blank_mask     out  4   bit i set: digit i was blank in the committed frame
//  - dp_op          out  4   bit i set: dot of digit i was lit (cathode_n[7]==0)
//  - frame_valid    out  1   1-cycle pulse on every commit
//  - bcd_data_valid out  1   level; set on commit, cleared after STALE_CYCLES cycles without a commit
//  - err_pattern    out  1   1-cycle pulse: illegal segment pattern seen while collecting
//  - err_sequence   out  1   1-cycle pulse: illegal anode code or out-of-order digit while collecting
// BEHAVIOUR
//  - Reset: bcd_data_op=16'h0000, blank_mask=4'hF, dp_op=0, all pulses/levels 0, state HUNT, stale cnt=0.
//  - Inputs sampled at each posedge; decode is combinational from the ports; every output is registered.
//  - Pattern decode on cathode_n[6:0]: 40=0 79=1 24=2 30=3 19=4 12=5 02=6 78=7 00=8 10=9, 7F=blank (4'hF).
//    Any other code is illegal.
//  - HUNT: wait for anode_n==1110 with a legal pattern; capture d0 and go to COLLECT, expected index 1.
//    No error flags are raised in HUNT.
//  - COLLECT: anode_n must equal the expected index code and the pattern must be legal; capture digit.
//    Increment the expected index; after d3 is captured, commit and return to HUNT.
//  - Illegal pattern in COLLECT: err_pattern pulse, partial frame discarded, go to HUNT.
//  - Illegal anode (not one-hot-zero, incl. 1111) or wrong index in COLLECT: err_sequence pulse, discard.
//    If the anode is 1110 with a legal pattern, restart COLLECT with d0 captured; else go to HUNT.
//  - Illegal pattern and bad anode in the same cycle: err_sequence only.
//  - Commit: at the edge sampling d3, bcd_data_op/blank_mask/dp_op update, frame_valid=1 for one cycle,
//    bcd_data_valid=1 and the stale counter clears. Latency is 0 cycles after the d3 sample.
//  - Stale counter: saturating, +1 per non-commit cycle; at ==STALE_CYCLES bcd_data_valid<=0 and data holds.
//    A commit in the same cycle wins.
//  - Reset mid-frame discards partial capture; no pulses are issued on the reset edge.
// CONFIGURATION
//  - SEG7_DEC_STABLE_EN defined: a complete frame commits only if it is identical to the previous
//    complete frame (digits, blanks, dots). The first frame after reset, an error or a mismatch is held
//    as candidate only. Errors clear the candidate.
//  - Undefined: every complete error-free frame commits.
// STRUCTURE
//  - Package seg7_pkg: active-low segment code constants 0-9 and BLANK, anode digit codes, state enum
//    {HUNT, COLLECT}, BLANK_BCD=4'hF.
//  - Sub-module seg7_pattern_decode: combinational cathode_n[6:0] -> {legal, blank, bcd[3:0]}.
//  - Top holds the FSM, digit index, staging registers, candidate (under macro) and stale counter.
// TESTING
//  - Frame 1110/F9, 1101/A4, 1011/B0, 0111/99 -> bcd_data_op=16'h4321, frame_valid 1 cycle,
//    bcd_data_valid=1, blank_mask=0.
//  - Frame with d2 cathode=FF and d0 cathode=79 (dot lit) -> bcd_data_op[11:8]=F, blank_mask=0100,
//    dp_op=0001.
//  - d1 cathode=0xA5 (illegal) -> err_pattern pulse, no commit; next clean frame commits normally.
//  - Sequence 1110, 1011 -> err_sequence pulse; 1110, 1110 -> err_sequence and restart with new d0;
//    1100 -> err_sequence.
//  - After one commit hold anode_n=1111 -> bcd_data_valid drops exactly 16 cycles later, data unchanged.
//  - Reset asserted after d1 sampled -> all outputs at reset values; the following full frame commits.
//  - SEG7_DEC_STABLE_EN: frames 1234, 1234 -> commit only on the second; 1234, 5678, 5678 -> commit 5678
//    on the third.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan-bus decoder: active-low
// segment codes, anode digit codes, FSM state and the committed-frame record.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_D0 = 4'b1110;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D3 = 4'b0111;

    localparam logic [3:0] BLANK_BCD = 4'hF;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic [3:0]  dp;
    } frame_t;

    function automatic logic [3:0] anode_code(input logic [1:0] idx);
        case (idx)
            2'd0:    return AN_D0;
            2'd1:    return AN_D1;
            2'd2:    return AN_D2;
            default: return AN_D3;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one active-low g..a segment pattern back to a BCD
// digit; blank decodes to BLANK_BCD, anything unlisted is flagged illegal.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       legal,
    output logic       blank,
    output logic [3:0] bcd
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        legal = 1'b1;
        blank = 1'b0;
        bcd   = 4'h0;
        case (seg_n)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: begin
                blank = 1'b1;
                bcd   = BLANK_BCD;
            end
            default: begin
                legal = 1'b0;
                bcd   = BLANK_BCD;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the 4-digit multiplexed 7-segment scan bus: reassembles frames
// and publishes BCD. Define SEG7_DEC_STABLE_EN to commit only repeated frames.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STALE_CYCLES = 16
) (
    input  logic        clk_1khz,
    input  logic        reset,
    input  logic [3:0]  anode_n,
    input  logic [7:0]  cathode_n,
    output logic [15:0] bcd_data_op,
    output logic [3:0]  blank_mask,
    output logic [3:0]  dp_op,
    output logic        frame_valid,
    output logic        bcd_data_valid,
    output logic        err_pattern,
    output logic        err_sequence
);

    localparam int               CNT_W     = $clog2(STALE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_CYCLES);

    logic       pat_legal;
    logic       pat_blank;
    logic [3:0] pat_bcd;

    seg7_pattern_decode u_pattern_decode (
        .seg_n (cathode_n[6:0]),
        .legal (pat_legal),
        .blank (pat_blank),
        .bcd   (pat_bcd)
    );

    state_e           state;
    logic [1:0]       idx;
    logic [11:0]      stage_bcd;
    logic [2:0]       stage_blank;
    logic [2:0]       stage_dp;
    logic [CNT_W-1:0] stale_cnt;

    logic   dot_lit;
    logic   d0_start;
    logic   anode_ok;
    logic   err_seq_now;
    logic   err_pat_now;
    logic   frame_done;
    logic   shift_en;
    logic   commit;
    frame_t full_frame;

    assign dot_lit     = ~cathode_n[7];
    assign d0_start    = (anode_n == AN_D0) && pat_legal;
    assign anode_ok    = (anode_n == anode_code(idx));
    assign err_seq_now = (state == COLLECT) && !anode_ok;
    assign err_pat_now = (state == COLLECT) && anode_ok && !pat_legal;
    assign frame_done  = (state == COLLECT) && anode_ok && pat_legal && (idx == 2'd3);

    // Digits arrive strictly d0,d1,d2 before d3, so a shift register always holds {d2,d1,d0} at d3.
    assign shift_en = (d0_start && ((state == HUNT) || err_seq_now))
                    || ((state == COLLECT) && anode_ok && pat_legal);

    assign full_frame = '{bcd:   {pat_bcd, stage_bcd},
                          blank: {pat_blank, stage_blank},
                          dp:    {dot_lit, stage_dp}};

`ifdef SEG7_DEC_STABLE_EN
    frame_t cand;
    logic   cand_valid;

    assign commit = frame_done && cand_valid && (full_frame == cand);

    always_ff @(posedge clk_1khz) begin
        if (reset) begin
            cand       <= '0;
            cand_valid <= 1'b0;
        end else if (err_seq_now || err_pat_now) begin
            cand_valid <= 1'b0;
        end else if (frame_done) begin
            cand       <= full_frame;
            cand_valid <= 1'b1;
        end
    end
`else
    assign commit = frame_done;
`endif

    // NOTE: registers are written with <= only, so each sees its peers' pre-edge values.
    always_ff @(posedge clk_1khz) begin
        if (reset) begin
            state        <= HUNT;
            idx          <= 2'd0;
            stage_bcd    <= '0;
            stage_blank  <= '0;
            stage_dp     <= '0;
            err_pattern  <= 1'b0;
            err_sequence <= 1'b0;
        end else begin
            err_pattern  <= err_pat_now;
            err_sequence <= err_seq_now;
            case (state)
                HUNT: begin
                    if (d0_start) begin
                        state <= COLLECT;
                        idx   <= 2'd1;
                    end
                end
                COLLECT: begin
                    if (err_seq_now) begin
                        state <= d0_start ? COLLECT : HUNT;
                        idx   <= 2'd1;
                    end else if (err_pat_now || frame_done) begin
                        state <= HUNT;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                default: state <= HUNT;
            endcase
            if (shift_en) begin
                stage_bcd   <= {pat_bcd, stage_bcd[11:4]};
                stage_blank <= {pat_blank, stage_blank[2:1]};
                stage_dp    <= {dot_lit, stage_dp[2:1]};
            end
        end
    end

    always_ff @(posedge clk_1khz) begin
        if (reset) begin
            bcd_data_op <= 16'h0000;
            blank_mask  <= 4'hF;
            dp_op       <= 4'h0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (commit) begin
                bcd_data_op <= full_frame.bcd;
                blank_mask  <= full_frame.blank;
                dp_op       <= full_frame.dp;
            end
        end
    end

    // Valid drops on the STALE_CYCLES-th consecutive edge without a commit.
    always_ff @(posedge clk_1khz) begin
        if (reset) begin
            stale_cnt      <= '0;
            bcd_data_valid <= 1'b0;
        end else if (commit) begin
            stale_cnt      <= '0;
            bcd_data_valid <= 1'b1;
        end else if (stale_cnt != STALE_MAX) begin
            stale_cnt <= stale_cnt + 1'b1;
            if (stale_cnt == STALE_MAX - 1'b1) begin
                bcd_data_valid <= 1'b0;
            end
        end
    end

endmodule
